// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int calc_div(input longint clk_freq, input longint baud);
    return int'((clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE));
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; the head is driven as zero while empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_pi,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A read frees the slot a same-cycle write needs, so both go through when full.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk_pi or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pi) begin
    if (do_wr && !clear) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver: 16x oversampled framing FSM feeding a FWFT FIFO.
// Frames failing parity or stop checks are dropped and reported via sticky flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int           CLK_FREQ    = 100_000_000,
  parameter int           BAUD        = 115200,
  parameter int           DATA_BITS   = 8,
  parameter parity_mode_t PARITY_MODE = PAR_NONE,
  parameter int           STOP_BITS   = 1,
  parameter int           FIFO_DEPTH  = 16
) (
  input  logic                          clk_pi,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en_pi,
  input  logic                          clear_pi,
  output logic [DATA_BITS-1:0]          data_po,
  output logic                          empty_po,
  output logic                          full_po,
  output logic [$clog2(FIFO_DEPTH):0]   count_po,
  output logic                          parity_err_po,
  output logic                          frame_err_po,
  output logic                          overrun_po
);

  localparam int         DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int         DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) == (PARITY_MODE == PAR_ODD);
  endfunction

  logic                 rx_p0;
  logic                 rx_p1;
  logic                 rx_prev;
  logic                 line;
  logic                 fall;
  rx_state_t            state;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 sample;
  logic [DATA_BITS-1:0] shreg;
  logic                 bad_parity;
  logic                 bad_frame;
  logic                 frame_end;
  logic                 frame_bad;
  logic                 wr_en;
  logic                 fifo_full;

  // Stage 0/1: line synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge clk_pi or negedge rst) begin
    if (!rst) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_p1   <= rx_p0;
      rx_prev <= rx_p1;
    end
  end

  assign line = rx_p1;
  assign fall = rx_prev & ~rx_p1;

  always_ff @(posedge clk_pi or negedge rst) begin
    if (!rst)                       div_cnt <= '0;
    else if (state == IDLE || tick) div_cnt <= '0;
    else                            div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));

  // The start bit is checked half a bit in; every later sample lands one bit further on.
  assign sample = tick && (tick_cnt == ((state == START) ? MID_TICK : LAST_TICK));

  always_ff @(posedge clk_pi or negedge rst) begin
    if (!rst)                         tick_cnt <= '0;
    else if (state == IDLE || sample) tick_cnt <= '0;
    else if (tick)                    tick_cnt <= tick_cnt + 1'b1;
  end

  assign frame_end = (state == STOP) && sample && (stop_cnt == LAST_STOP);
  assign frame_bad = bad_frame | ~line;
  assign wr_en     = frame_end & ~frame_bad & ~bad_parity;

  always_ff @(posedge clk_pi or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      bad_parity <= 1'b0;
      bad_frame  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          bad_parity <= 1'b0;
          bad_frame  <= 1'b0;
          if (fall) state <= START;
        end
        START: begin
          if (sample) state <= line ? IDLE : DATA;
        end
        DATA: begin
          if (sample) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample) begin
            bad_parity <= ~parity_ok(shreg, line);
            state      <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (!line) bad_frame <= 1'b1;
            if (stop_cnt == LAST_STOP) state <= frame_bad ? WAIT_IDLE : IDLE;
            else                       stop_cnt <= stop_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pi) begin
    if (state == DATA && sample) shreg <= {line, shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk_pi or negedge rst) begin
    if (!rst) begin
      parity_err_po <= 1'b0;
      frame_err_po  <= 1'b0;
      overrun_po    <= 1'b0;
    end else if (clear_pi) begin
      parity_err_po <= 1'b0;
      frame_err_po  <= 1'b0;
      overrun_po    <= 1'b0;
    end else begin
      if (frame_end && bad_parity)             parity_err_po <= 1'b1;
      if (frame_end && frame_bad)              frame_err_po  <= 1'b1;
      if (wr_en && fifo_full && !rd_en_pi)     overrun_po    <= 1'b1;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pi  (clk_pi),
    .rst     (rst),
    .clear   (clear_pi),
    .wr_en   (wr_en),
    .wr_data (shreg),
    .rd_en   (rd_en_pi),
    .rd_data (data_po),
    .full    (fifo_full),
    .empty   (empty_po),
    .count   (count_po)
  );

  assign full_po = fifo_full;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning payload bits per frame.
REQ-004 SHALL have parameter PARITY_MODE, default PAR_NONE, legal PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, a power of 2 and at least 2.
REQ-007 SHALL have port clk_pi, input, 1 bit, the single clock.
REQ-008 SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-009 SHALL have port rx, input, 1 bit, the asynchronous serial line; it idles high.
REQ-010 SHALL have port rd_en_pi, input, 1 bit, which pops the FIFO head.
REQ-011 SHALL have port clear_pi, input, 1 bit, which flushes the FIFO and the sticky flags.
REQ-012 SHALL have port data_po, output, DATA_BITS wide, the FIFO head (first-word fall-through).
REQ-013 SHALL have ports empty_po and full_po, outputs, 1 bit each, the FIFO status.
REQ-014 SHALL have port count_po, output, $clog2(FIFO_DEPTH)+1 wide, the FIFO occupancy.
REQ-015 SHALL have ports parity_err_po, frame_err_po and overrun_po, outputs, 1 bit each, sticky error flags.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser with both flops reset to 1; all line logic uses the synchronised value.
REQ-017 SHALL generate a 1-clock tick every DIV = round(CLK_FREQ/(BAUD*16)) clocks (54 at default values); the tick counter runs only outside IDLE and restarts at 0 on leaving IDLE.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-019 SHALL move IDLE->START on a synchronised 1->0 edge.
REQ-020 In START, at tick 8, SHALL go to DATA if the line is 0, otherwise return to IDLE (false start, nothing stored).
REQ-021 In DATA, SHALL sample every 16th tick, LSB first, for DATA_BITS samples, then go to PARITY if PARITY_MODE!=PAR_NONE, else to STOP.
REQ-022 In PARITY, SHALL sample once; a mismatch (even: XOR of data and parity must be 0; odd: it must be 1) marks the frame bad_parity.
REQ-023 In STOP, SHALL sample STOP_BITS times, 16 ticks apart; any 0 sample marks the frame bad_frame.
REQ-024 On the last stop sample, a good frame SHALL be written to the FIFO; empty_po falls and data_po is valid 1 clock later.
REQ-025 A bad frame SHALL be discarded; bad_parity sets parity_err_po, bad_frame sets frame_err_po; if bad_frame, SHALL go to WAIT_IDLE, else IDLE.
REQ-026 WAIT_IDLE SHALL hold until the line reads 1 (break handling), then go to IDLE.
REQ-027 A write while full and not reading SHALL drop the byte and set overrun_po; a write and a read in the same cycle while full SHALL both succeed.
REQ-028 rd_en_pi while empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-029 clear_pi SHALL, in the next cycle, zero count, pointers and all sticky flags; clear_pi wins over a simultaneous write or read; it does not abort a frame in progress.
REQ-030 Error flags SHALL stay set until clear_pi or reset.

Reset
REQ-031 Asserting rst low SHALL immediately force FSM=IDLE, counters=0, FIFO empty (empty_po=1, full_po=0, count_po=0), data_po=0, and all error flags=0.
REQ-032 Reset asserted mid-frame SHALL drop the partial frame; reception SHALL resume at the first falling edge after release.

Structure
REQ-033 Package uart_pkg SHALL hold the parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD), the rx_state_t enum and OVERSAMPLE=16.
REQ-034 The FIFO SHALL be a sub-module uart_rx_fifo (parameters WIDTH and DEPTH; FWFT; full, empty and count outputs); the tick generator and FSM SHALL be inline.

Verification (defaults unless stated; bit period 864 clocks)
REQ-035 8N1 frame 0xA5 -> data_po=0xA5, count_po=1, no flags; rd_en_pi for 1 clock -> empty_po=1.
REQ-036 PARITY_MODE=PAR_EVEN, frame 0x3C with parity bit 1 -> FIFO empty, parity_err_po=1 until clear_pi.
REQ-037 Frame 0x55 with stop=0 and line held low 2 bit times -> frame_err_po=1, FIFO empty; a following frame 0x12 -> data_po=0x12.
REQ-038 rx low for 300 clocks then high -> no write, FSM back in IDLE.
REQ-039 16 frames 0x00..0x0F, then 0xFF -> full_po=1, overrun_po=1, data_po=0x00; 16 reads return 0x00..0x0F in order.
REQ-040 rst low during data bit 3 of 0x81 -> all outputs at reset values; the next frame 0x7E is received correctly.
